// File: rtl/usb_rx_packet_check.sv
// usb_rx_packet_check
//
// Receive-side packet layer of the serial interface engine. Consumes the
// (control, data) byte stream from the RX bit processor, validates the PID,
// checks CRC5 on tokens and CRC16 on data packets, extracts token fields and
// forwards data-packet bytes (CRC bytes included) into the RX data FIFO.
// One status word is published per packet, flagged by a rxPktDone pulse.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   RxCtrlIn            byte type: 0 SOP, 1 EOP, 2 data, 3 bit-stuff error
//   RxDataIn            byte value (valid for RxCtrlIn = 2)
//   processRxByteWEn    write strobe from the bit processor
//   processRxByteRdy    ready to accept a byte
//   fifoWEn, fifoData   write port into the RX data FIFO
//   fifoFull            RX data FIFO full
//   rxPID               PID[3:0] of the last packet
//   rxAddr, rxEndP      token address / endpoint
//   rxFrameNum          SOF frame number
//   rxStatus            {formatErr, overflow, bitStuffErr, crcErr, pidErr}
//   rxPktDone           one-cycle pulse when the packet result is valid
module usb_rx_packet_check (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  RxCtrlIn,
    input  logic [7:0]  RxDataIn,
    input  logic        processRxByteWEn,
    output logic        processRxByteRdy,
    output logic        fifoWEn,
    output logic [7:0]  fifoData,
    input  logic        fifoFull,
    output logic [3:0]  rxPID,
    output logic [6:0]  rxAddr,
    output logic [3:0]  rxEndP,
    output logic [10:0] rxFrameNum,
    output logic [4:0]  rxStatus,
    output logic        rxPktDone
);

    typedef enum logic [2:0] {
        StIdle, StPid, StTok1, StTok2, StData, StWaitEnd, StDone
    } state_e;

    localparam logic [4:0] PidErr   = 5'b00001;
    localparam logic [4:0] CrcErr   = 5'b00010;
    localparam logic [4:0] StuffErr = 5'b00100;
    localparam logic [4:0] OvfErr   = 5'b01000;
    localparam logic [4:0] FmtErr   = 5'b10000;

    // Bit-serial CRC folded over one byte, LSB first.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = {r[3:0], 1'b0} ^ ((d[i] ^ r[4]) ? 5'h05 : 5'h00);
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    state_e      state_q;
    logic        rdy_q, fifo_wen_q, pkt_done_q, restart_q;
    logic [7:0]  fifo_data_q, tok1_q;
    logic [3:0]  pid_q, endp_q;
    logic [6:0]  addr_q;
    logic [10:0] frame_q;
    logic [4:0]  status_q;
    logic [4:0]  crc5_q;
    logic [15:0] crc16_q;
    logic [1:0]  data_cnt_q;

    logic        accept, is_sop, is_eop, is_data, is_stuff, pid_bad;
    logic [4:0]  crc5_d, status_base;
    logic [15:0] crc16_d;

    always_comb begin
        accept   = processRxByteWEn & rdy_q;
        is_sop   = (RxCtrlIn == 8'd0);
        is_eop   = (RxCtrlIn == 8'd1);
        is_data  = (RxCtrlIn == 8'd2);
        is_stuff = (RxCtrlIn == 8'd3);
        pid_bad  = (RxDataIn[7:4] != ~RxDataIn[3:0]);
        crc5_d   = crc5_byte(crc5_q, RxDataIn);
        crc16_d  = crc16_byte(crc16_q, RxDataIn);
        // After an aborted packet the previous status stays visible through the
        // DONE pulse; the new packet accumulates from zero.
        status_base = (state_q == StPid && restart_q) ? 5'b00000 : status_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rdy_q       <= 1'b1;
            fifo_wen_q  <= 1'b0;
            fifo_data_q <= 8'h00;
            pkt_done_q  <= 1'b0;
            restart_q   <= 1'b0;
            tok1_q      <= 8'h00;
            pid_q       <= 4'h0;
            addr_q      <= 7'h00;
            endp_q      <= 4'h0;
            frame_q     <= 11'h000;
            status_q    <= 5'b00000;
            crc5_q      <= 5'h1F;
            crc16_q     <= 16'hFFFF;
            data_cnt_q  <= 2'd0;
        end else begin
            fifo_wen_q <= 1'b0;
            pkt_done_q <= 1'b0;
            rdy_q      <= ~accept;
            if (state_q == StPid && restart_q) begin
                status_q  <= 5'b00000;
                restart_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (accept && is_sop) begin
                        status_q   <= 5'b00000;
                        crc5_q     <= 5'h1F;
                        crc16_q    <= 16'hFFFF;
                        data_cnt_q <= 2'd0;
                        state_q    <= StPid;
                    end
                end
                StDone: begin
                    pkt_done_q <= 1'b1;
                    state_q    <= restart_q ? StPid : StIdle;
                end
                default: begin
                    if (accept) begin
                        if (is_sop) begin
                            status_q   <= status_base | FmtErr;
                            restart_q  <= 1'b1;
                            crc5_q     <= 5'h1F;
                            crc16_q    <= 16'hFFFF;
                            data_cnt_q <= 2'd0;
                            state_q    <= StDone;
                        end else if (is_stuff) begin
                            status_q <= status_base | StuffErr;
                            state_q  <= StDone;
                        end else if (is_eop) begin
                            state_q <= StDone;
                            case (state_q)
                                StPid, StTok1, StTok2: status_q <= status_base | FmtErr;
                                StData: begin
                                    if (data_cnt_q != 2'd2) begin
                                        status_q <= status_base | FmtErr | CrcErr;
                                    end else if (crc16_q != 16'h800D) begin
                                        status_q <= status_base | CrcErr;
                                    end
                                end
                                default: ;
                            endcase
                        end else if (is_data) begin
                            case (state_q)
                                StPid: begin
                                    pid_q    <= RxDataIn[3:0];
                                    status_q <= status_base | (pid_bad ? PidErr : 5'b00000);
                                    // A PID failing its check cannot be trusted to select a class.
                                    if (pid_bad) begin
                                        state_q <= StWaitEnd;
                                    end else begin
                                        case (RxDataIn[3:0])
                                            4'b0001, 4'b1001, 4'b1101, 4'b0101: state_q <= StTok1;
                                            4'b0011, 4'b1011:                   state_q <= StData;
                                            default:                            state_q <= StWaitEnd;
                                        endcase
                                    end
                                end
                                StTok1: begin
                                    tok1_q  <= RxDataIn;
                                    crc5_q  <= crc5_d;
                                    state_q <= StTok2;
                                end
                                StTok2: begin
                                    crc5_q <= crc5_d;
                                    if (crc5_d != 5'h0C) begin
                                        status_q <= status_base | CrcErr;
                                    end
                                    if (pid_q == 4'b0101) begin
                                        frame_q <= {RxDataIn[2:0], tok1_q};
                                    end else begin
                                        addr_q <= tok1_q[6:0];
                                        endp_q <= {RxDataIn[2:0], tok1_q[7]};
                                    end
                                    state_q <= StWaitEnd;
                                end
                                StData: begin
                                    crc16_q <= crc16_d;
                                    if (data_cnt_q != 2'd2) begin
                                        data_cnt_q <= data_cnt_q + 2'd1;
                                    end
                                    if (fifoFull) begin
                                        status_q <= status_base | OvfErr;
                                    end else begin
                                        fifo_wen_q  <= 1'b1;
                                        fifo_data_q <= RxDataIn;
                                    end
                                end
                                StWaitEnd: status_q <= status_base | FmtErr;
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign processRxByteRdy = rdy_q;
    assign fifoWEn          = fifo_wen_q;
    assign fifoData         = fifo_data_q;
    assign rxPID            = pid_q;
    assign rxAddr           = addr_q;
    assign rxEndP           = endp_q;
    assign rxFrameNum       = frame_q;
    assign rxStatus         = status_q;
    assign rxPktDone        = pkt_done_q;

endmodule

// File: tb/tb_usb_rx_packet_check.sv
// Testbench for usb_rx_packet_check: directed packets from the test plan plus
// randomized tokens, data packets and handshakes against a packet-level model.
module tb_usb_rx_packet_check;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  ctrl, data;
    logic        wen, rdy, fifo_wen, fifo_full, pkt_done;
    logic [7:0]  fifo_data;
    logic [3:0]  rx_pid, rx_endp;
    logic [6:0]  rx_addr;
    logic [10:0] rx_frame;
    logic [4:0]  rx_status;

    always #5 clk = ~clk;

    usb_rx_packet_check dut (
        .clk              (clk),
        .rst              (rst),
        .RxCtrlIn         (ctrl),
        .RxDataIn         (data),
        .processRxByteWEn (wen),
        .processRxByteRdy (rdy),
        .fifoWEn          (fifo_wen),
        .fifoData         (fifo_data),
        .fifoFull         (fifo_full),
        .rxPID            (rx_pid),
        .rxAddr           (rx_addr),
        .rxEndP           (rx_endp),
        .rxFrameNum       (rx_frame),
        .rxStatus         (rx_status),
        .rxPktDone        (pkt_done)
    );

    typedef struct { logic [7:0] c; logic [7:0] d; logic full; } item_t;
    typedef struct packed {
        logic [3:0] pid; logic [6:0] addr; logic [3:0] endp; logic [10:0] frame; logic [4:0] status;
    } snap_t;

    localparam logic [4:0] PID_E = 5'b00001, CRC_E = 5'b00010, STF_E = 5'b00100;
    localparam logic [4:0] OVF_E = 5'b01000, FMT_E = 5'b10000;

    int         n_cmp = 0, n_err = 0;
    item_t      items[$];
    logic [7:0] exp_fifo[$], fifo_log[$];
    snap_t      snaps[$];
    logic [3:0] exp_pid = 0, exp_endp = 0;
    logic [6:0] exp_addr = 0;
    logic [10:0] exp_frame = 0;
    logic [4:0] exp_status;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fifo_wen) fifo_log.push_back(fifo_data);
        if (pkt_done) snaps.push_back({rx_pid, rx_addr, rx_endp, rx_frame, rx_status});
    end

    function automatic logic [4:0] crc5_bits(input logic [10:0] b);
        logic [4:0] c;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) c = {c[3:0], 1'b0} ^ ((b[i] ^ c[4]) ? 5'h05 : 5'h00);
        return c;
    endfunction

    function automatic logic [15:0] crc16_q(input logic [7:0] q[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[k])
            for (int i = 0; i < 8; i++) c = {c[14:0], 1'b0} ^ ((q[k][i] ^ c[15]) ? 16'h8005 : 16'h0);
        return c;
    endfunction

    function automatic logic is_tok(input logic [3:0] p);
        return (p == 4'h1 || p == 4'h9 || p == 4'hD || p == 4'h5);
    endfunction

    function automatic logic is_dat(input logic [3:0] p);
        return (p == 4'h3 || p == 4'hB);
    endfunction

    task automatic add(input logic [7:0] c, input logic [7:0] d, input logic full);
        item_t it;
        it.c = c; it.d = d; it.full = full;
        items.push_back(it);
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] d, input logic full);
        int guard = 0;
        @(negedge clk);
        while (!rdy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!rdy) check_val("rdy_timeout", rdy, 1);
        ctrl = c; data = d; fifo_full = full; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0; fifo_full = 1'b0;
    endtask

    task automatic run_expect(input string tag, input int exp_pulses);
        snap_t s;
        fifo_log.delete();
        snaps.delete();
        foreach (items[i]) send(items[i].c, items[i].d, items[i].full);
        repeat (4) @(negedge clk);
        check_val({tag, "_pulses"}, snaps.size(), exp_pulses);
        check_val({tag, "_nwr"}, fifo_log.size(), exp_fifo.size());
        for (int i = 0; i < fifo_log.size() && i < exp_fifo.size(); i++)
            check_val({tag, "_wr"}, fifo_log[i], exp_fifo[i]);
        if (snaps.size() > 0) begin
            s = snaps[snaps.size() - 1];
            check_val({tag, "_pid"}, s.pid, exp_pid);
            check_val({tag, "_addr"}, s.addr, exp_addr);
            check_val({tag, "_endp"}, s.endp, exp_endp);
            check_val({tag, "_frame"}, s.frame, exp_frame);
            check_val({tag, "_status"}, s.status, exp_status);
        end
        items.delete();
        exp_fifo.delete();
    endtask

    // Data packet from payload + generated CRC; returns full byte list in body.
    task automatic make_data(input logic [7:0] pay[$], output logic [7:0] body[$]);
        logic [15:0] c;
        logic [7:0] b1, b2;
        c = ~crc16_q(pay);
        for (int i = 0; i < 8; i++) begin
            b1[i] = c[15 - i];
            b2[i] = c[7 - i];
        end
        body = pay;
        body.push_back(b1);
        body.push_back(b2);
    endtask

    task automatic rand_idle_junk();
        if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
                0: add(8'd1, 8'h00, 1'b0);
                1: add(8'd2, 8'($urandom), 1'b0);
                default: add(8'($urandom_range(4, 255)), 8'($urandom), 1'b0);
            endcase
        end
    endtask

    task automatic rand_token();
        logic [3:0] p, endp;
        logic [6:0] addr;
        logic [4:0] c;
        logic [7:0] b1, b2;
        logic corrupt, extra;
        int trunc;
        case ($urandom_range(0, 3))
            0: p = 4'h1; 1: p = 4'h9; 2: p = 4'hD; default: p = 4'h5;
        endcase
        addr = 7'($urandom); endp = 4'($urandom);
        b1 = {endp[0], addr};
        c = ~crc5_bits({endp, addr});
        b2 = {c[0], c[1], c[2], c[3], c[4], endp[3:1]};
        corrupt = ($urandom_range(0, 3) == 0);
        if (corrupt) b2 = b2 ^ (8'h08 << $urandom_range(0, 4));
        trunc = $urandom_range(0, 5);
        extra = ($urandom_range(0, 4) == 0);
        rand_idle_junk();
        add(8'd0, 8'h00, 1'b0);
        add(8'd2, {~p, p}, 1'b0);
        exp_pid = p;
        if (trunc >= 1) add(8'd2, b1, 1'b0);
        if (trunc >= 2) begin
            add(8'd2, b2, 1'b0);
            if (p == 4'h5) exp_frame = {endp, addr};
            else begin exp_addr = addr; exp_endp = endp; end
            if (extra) add(8'd2, 8'($urandom), 1'b0);
            exp_status = (corrupt ? CRC_E : 5'b0) | (extra ? FMT_E : 5'b0);
        end else begin
            exp_status = FMT_E;
        end
        add(8'd1, 8'h00, 1'b0);
        run_expect("tok", 1);
    endtask

    task automatic rand_datapkt();
        logic [7:0] pay[$], body[$];
        logic [3:0] p;
        logic corrupt, ovf, full;
        int n, mode, sent, idx;
        p = $urandom_range(0, 1) ? 4'h3 : 4'hB;
        n = $urandom_range(0, 5);
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
        make_data(pay, body);
        corrupt = ($urandom_range(0, 3) == 0);
        if (corrupt) begin
            idx = $urandom_range(0, body.size() - 1);
            body[idx] = body[idx] ^ (8'h01 << $urandom_range(0, 7));
        end
        mode = $urandom_range(0, 5);
        if (mode == 4) sent = $urandom_range(0, 1);
        else if (mode == 5) sent = $urandom_range(0, body.size());
        else sent = body.size();
        rand_idle_junk();
        add(8'd0, 8'h00, 1'b0);
        add(8'd2, {~p, p}, 1'b0);
        exp_pid = p;
        ovf = 1'b0;
        for (int i = 0; i < sent; i++) begin
            full = ($urandom_range(0, 3) == 0);
            add(8'd2, body[i], full);
            if (full) ovf = 1'b1;
            else exp_fifo.push_back(body[i]);
        end
        if (mode == 5) begin
            add(8'd3, 8'h00, 1'b0);
            exp_status = STF_E;
        end else begin
            add(8'd1, 8'h00, 1'b0);
            if (mode == 4) exp_status = CRC_E | FMT_E;
            else exp_status = corrupt ? CRC_E : 5'b0;
        end
        if (ovf) exp_status = exp_status | OVF_E;
        run_expect("data", 1);
    endtask

    task automatic rand_other();
        logic [3:0] p, up;
        logic perr, extra;
        p = 4'($urandom);
        perr = (is_tok(p) || is_dat(p)) ? 1'b1 : ($urandom_range(0, 3) == 0);
        up = perr ? (~p ^ 4'($urandom_range(1, 15))) : ~p;
        extra = ($urandom_range(0, 2) == 0);
        rand_idle_junk();
        add(8'd0, 8'h00, 1'b0);
        add(8'd2, {up, p}, 1'b0);
        if (extra) add(8'd2, 8'($urandom), 1'b0);
        add(8'd1, 8'h00, 1'b0);
        exp_pid = p;
        exp_status = (perr ? PID_E : 5'b0) | (extra ? FMT_E : 5'b0);
        run_expect("hs", 1);
    endtask

    initial begin
        logic [7:0] pay[$], body[$];
        int nw, np;
        rst = 1'b1; ctrl = 8'h00; data = 8'h00; wen = 1'b0; fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_rdy", rdy, 1);
        check_val("rst_fifo", {fifo_wen, fifo_data}, 0);
        check_val("rst_fields", {rx_pid, rx_addr, rx_endp, rx_frame}, 0);
        check_val("rst_status", {rx_status, pkt_done}, 0);

        // Ready timing; a WEn while not ready must be ignored.
        send(8'h07, 8'h00, 1'b0);
        check_val("rdy_low", rdy, 0);
        ctrl = 8'd0; wen = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        check_val("rdy_high", rdy, 1);
        fifo_log.delete(); snaps.delete();
        send(8'd2, 8'hD2, 1'b0);
        send(8'd1, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        check_val("ignored_sop", snaps.size(), 0);

        add(0, 0, 0); add(2, 8'h2D, 0); add(2, 8'h00, 0); add(2, 8'h10, 0); add(1, 0, 0);
        exp_pid = 4'hD; exp_addr = 0; exp_endp = 0; exp_status = 0;
        run_expect("setup", 1);

        add(0, 0, 0); add(2, 8'h2D, 0); add(2, 8'h00, 0); add(2, 8'h11, 0); add(1, 0, 0);
        exp_endp = 4'h2; exp_status = CRC_E;
        run_expect("tok_crc", 1);

        add(0, 0, 0); add(2, 8'hC3, 0); add(2, 8'h00, 0); add(2, 8'h00, 0); add(1, 0, 0);
        exp_fifo = '{8'h00, 8'h00}; exp_pid = 4'h3; exp_status = 0;
        run_expect("zlp", 1);

        add(0, 0, 0); add(2, 8'hD3, 0); add(1, 0, 0);
        exp_pid = 4'h3; exp_status = PID_E;
        run_expect("bad_pid", 1);

        add(0, 0, 0); add(2, 8'hD2, 0); add(1, 0, 0);
        exp_pid = 4'h2; exp_status = 0;
        run_expect("ack", 1);

        add(0, 0, 0); add(2, 8'hC3, 0); add(2, 8'h55, 0); add(3, 0, 0);
        exp_fifo = '{8'h55}; exp_pid = 4'h3; exp_status = STF_E;
        run_expect("stuff", 1);

        add(0, 0, 0); add(2, 8'hD2, 0); add(2, 8'h00, 0); add(1, 0, 0);
        exp_pid = 4'h2; exp_status = FMT_E;
        run_expect("fmt", 1);

        pay = '{8'hA5, 8'h5A};
        make_data(pay, body);
        add(0, 0, 0); add(2, 8'hC3, 0);
        add(2, body[0], 0); add(2, body[1], 1); add(2, body[2], 1); add(2, body[3], 1);
        add(1, 0, 0);
        exp_fifo = '{8'hA5}; exp_pid = 4'h3; exp_status = OVF_E;
        run_expect("ovf", 1);

        // SOP mid-packet aborts, then the new packet proceeds.
        add(0, 0, 0); add(2, 8'hC3, 0); add(2, 8'h11, 0); add(0, 0, 0); add(2, 8'hD2, 0);
        add(1, 0, 0);
        exp_fifo = '{8'h11}; exp_pid = 4'h2; exp_status = 0;
        run_expect("abort", 2);
        if (snaps.size() == 2) begin
            check_val("abort_st0", snaps[0].status, FMT_E);
            check_val("abort_pid0", snaps[0].pid, 4'h3);
        end

        for (int i = 0; i < 45; i++) begin
            case ($urandom_range(0, 2))
                0: rand_token();
                1: rand_datapkt();
                default: rand_other();
            endcase
        end

        // Reset in the middle of a data packet.
        fifo_log.delete(); snaps.delete();
        send(8'd0, 8'h00, 1'b0);
        send(8'd2, 8'hC3, 1'b0);
        send(8'd2, 8'h12, 1'b0);
        @(negedge clk);
        nw = fifo_log.size(); np = snaps.size();
        check_val("mid_wr", nw, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_val("mid_rst_rdy", rdy, 1);
        check_val("mid_rst_fifo", {fifo_wen, fifo_data}, 0);
        check_val("mid_rst_fields", {rx_pid, rx_addr, rx_endp, rx_frame}, 0);
        check_val("mid_rst_status", {rx_status, pkt_done}, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_val("mid_no_wr", fifo_log.size(), nw);
        check_val("mid_no_pulse", snaps.size(), np);
        exp_pid = 0; exp_addr = 0; exp_endp = 0; exp_frame = 0;

        add(0, 0, 0); add(2, 8'hD2, 0); add(1, 0, 0);
        exp_pid = 4'h2; exp_status = 0;
        run_expect("post_rst", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb_rx_packet_check.md
# usb_rx_packet_check

Receive-side packet layer of the serial interface engine, directly downstream of the RX bit processor. It accepts the (control, data) byte stream produced by the bit processor, decodes and validates the PID, checks CRC5 (tokens) or CRC16 (data packets), extracts token fields, and forwards data-packet bytes into the RX data FIFO. It reports one status word per packet to the SIE control logic.

## Interface
- No parameters.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- RxCtrlIn  in  8  byte type from the bit processor: 0 = start of packet, 1 = end of packet, 2 = data byte, 3 = bit-stuff error; other values ignored
- RxDataIn  in  8  byte value, meaningful only when RxCtrlIn = 2
- processRxByteWEn  in  1  one-cycle write strobe from the bit processor
- processRxByteRdy  out  1  ready to accept a byte
- fifoWEn  out  1  one-cycle write strobe into the RX data FIFO
- fifoData  out  8  byte written to the FIFO
- fifoFull  in  1  RX data FIFO full
- rxPID  out  4  decoded PID[3:0] of the last packet
- rxAddr  out  7  token address field
- rxEndP  out  4  token endpoint field
- rxFrameNum  out  11  SOF frame number
- rxStatus  out  5  {formatErr, overflow, bitStuffErr, crcErr, pidErr}
- rxPktDone  out  1  one-cycle pulse; rxPID, rxAddr, rxEndP, rxFrameNum and rxStatus are valid from that cycle until the next pulse

## Operation
- Byte handshake:
  - A byte is accepted in a cycle where processRxByteWEn=1 and processRxByteRdy=1; a WEn pulse while Rdy=0 is ignored.
  - Rdy drops to 0 in the cycle after acceptance and returns to 1 one cycle later.
- States:
  - IDLE: only Ctrl=0 moves to PID; every other byte is discarded.
  - PID: the next data byte is the PID byte; pidErr is set if byte[7:4] != ~byte[3:0]. rxPID = byte[3:0]. Class is selected by rxPID:
    - token (0001 OUT, 1001 IN, 1101 SETUP, 0101 SOF) → TOK1
    - data (0011 DATA0, 1011 DATA1) → DATA
    - any other value → WAIT_END
  - TOK1 / TOK2: capture the two token bytes. rxAddr = b1[6:0]; rxEndP = {b2[2:0], b1[7]}. For SOF, rxFrameNum = {b2[2:0], b1[7:0]}; addr/endp are not updated on SOF. Then → WAIT_END.
  - DATA: every data byte is CRC16-updated and written to the FIFO, including the two trailing CRC bytes.
  - WAIT_END: any further data byte sets formatErr.
- End-of-packet handling:
  - Ctrl=1 in any non-IDLE state → DONE, which pulses rxPktDone and returns to IDLE.
  - An end-of-packet arriving before the PID, or before both token bytes, sets formatErr.
- Bit-stuff error:
  - Ctrl=3 in any state sets bitStuffErr and goes to DONE.
  - The bit processor sends no end-of-packet after a bit-stuff error.
- Start of packet outside IDLE: Ctrl=0 aborts the current packet with formatErr set (DONE pulse), then begins the new packet.
- Per-packet state clear: rxStatus is cleared on entry to PID; CRC registers are re-initialised there.
- CRC arithmetic (bit-serial semantics, LSB of each byte first, 8 bits folded per byte in one cycle):
  - CRC5: poly 5'h05, init 5'h1F. Step: fb = d ^ c[4]; c = {c[3:0],0} ^ (fb ? 5'h05 : 0). Covers all 16 bits of b1,b2; residual must equal 5'h0C.
  - CRC16: poly 16'h8005, init 16'hFFFF, same form. Residual over payload plus CRC bytes must equal 16'h800D.
  - Mismatch sets crcErr. A data packet with fewer than 2 bytes after the PID sets crcErr and formatErr.
- FIFO overflow: if fifoFull=1 when a data byte is to be written, the byte is dropped (no fifoWEn) and overflow is set. Later bytes still update the CRC.

## Timing
- Reset values:
  - processRxByteRdy = 1
  - fifoWEn = 0, fifoData = 0
  - rxPID = 0, rxAddr = 0, rxEndP = 0, rxFrameNum = 0
  - rxStatus = 0, rxPktDone = 0
  - state = IDLE
- Reset mid-packet: abandons the packet with no rxPktDone pulse and no FIFO write.
- Byte accepted in cycle N:
  - fifoWEn/fifoData are registered in cycle N+1 (one pulse).
  - Field and status registers update in N+1.
  - processRxByteRdy = 0 in N+1 and = 1 in N+2.
- End-of-packet accepted in cycle N: rxPktDone pulses in cycle N+2, with final rxStatus already valid.
- Fastest sustained input is one byte every 2 cycles; the bit processor delivers at most one byte per 8 bit times, so no back-pressure beyond Rdy is needed.

## Test plan
- SETUP token: bytes 0,2:0x2D,2:0x00,2:0x10,1 → rxPID=4'hD, rxAddr=0, rxEndP=0, rxStatus=0, one rxPktDone, no fifoWEn.
- Corrupted token: 0,2:0x2D,2:0x00,2:0x11,1 → rxStatus=5'b00010 (crcErr).
- Zero-length DATA0: 0,2:0xC3,2:0x00,2:0x00,1 → two fifoWEn writes of 0x00, rxPID=4'h3, rxStatus=0.
- Bad PID then handshake: 0,2:0xD3,1 → pidErr (5'b00001). Then 0,2:0xD2,1 → rxPID=4'h2, rxStatus=0.
- Bit-stuff and format errors: 0,2:0xC3,2:0x55,3 → bitStuffErr set, rxPktDone pulse, state IDLE. Separately, 0,2:0xD2,2:0x00,1 → formatErr (5'b10000).
- Overflow and reset:
  - DATA0 with 4 bytes and fifoFull held high from the 2nd byte → exactly 1 fifoWEn, overflow set.
  - rst asserted between bytes of a packet → all outputs return to reset values and no rxPktDone pulse occurs.
